// File: rtl/viterbi_decoder_param.sv
// Hard-decision rate-1/2 Viterbi decoder with full add-compare-select and
// register-exchange survivors; valid/ready handshake on input and output.
module viterbi_decoder_param #(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sym,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic [METRIC_W-1:0] out_metric
);

  localparam int SW = K - 1;
  localparam int NS = 1 << SW;
  localparam int CW = $clog2(TB_DEPTH + 1);

  localparam logic [METRIC_W-1:0] PM_MAX    = {METRIC_W{1'b1}};
  localparam logic [METRIC_W-1:0] PM_INIT   = {1'b1, {(METRIC_W-1){1'b0}}};
  localparam logic [CW-1:0]       FILL_FULL = CW'(TB_DEPTH);
  localparam logic [CW-1:0]       FILL_LAST = CW'(TB_DEPTH - 1);

  logic [METRIC_W-1:0] pm       [NS];
  logic [METRIC_W-1:0] pm_norm  [NS];
  logic [METRIC_W-1:0] pm_new   [NS];
  logic [TB_DEPTH-1:0] path     [NS];
  logic [TB_DEPTH-1:0] path_new [NS];
  logic [METRIC_W-1:0] pm_min;
  logic [METRIC_W-1:0] best_m;
  logic [SW-1:0]       best_st;
  logic [CW-1:0]       fill;
  logic                accept;
  logic                load;

  // Hamming distance between the received pair and the branch the encoder
  // would emit leaving state ps with input u.
  function automatic logic [1:0] branch_metric(input logic [SW-1:0] ps,
                                               input logic          u,
                                               input logic [1:0]    sym);
    logic [K-1:0] sr;
    logic [1:0]   diff;
    sr   = {u, ps};
    diff = sym ^ {^(sr & G0), ^(sr & G1)};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0]          b);
    logic [METRIC_W:0] sum;
    sum = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    return sum[METRIC_W] ? PM_MAX : sum[METRIC_W-1:0];
  endfunction

  always_comb begin
    pm_min = pm[0];
    for (int i = 1; i < NS; i++) begin
      if (pm[i] < pm_min) pm_min = pm[i];
    end
    for (int i = 0; i < NS; i++) begin
      pm_norm[i] = pm[i] - pm_min;
    end
  end

  // ACS: ties between the two predecessors resolve to the b=0 branch.
  always_comb begin
    logic [SW-1:0]       ns;
    logic [SW-1:0]       ps0;
    logic [SW-1:0]       ps1;
    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;
    logic                take1;
    ns    = '0;
    ps0   = '0;
    ps1   = '0;
    cand0 = '0;
    cand1 = '0;
    take1 = 1'b0;
    for (int i = 0; i < NS; i++) begin
      ns    = SW'(i);
      ps0   = {ns[SW-2:0], 1'b0};
      ps1   = {ns[SW-2:0], 1'b1};
      cand0 = sat_add(pm_norm[ps0], branch_metric(ps0, ns[SW-1], in_sym));
      cand1 = sat_add(pm_norm[ps1], branch_metric(ps1, ns[SW-1], in_sym));
      take1 = cand1 < cand0;
      pm_new[i]   = take1 ? cand1 : cand0;
      path_new[i] = take1 ? {path[ps1][TB_DEPTH-2:0], ns[SW-1]}
                          : {path[ps0][TB_DEPTH-2:0], ns[SW-1]};
    end
  end

  always_comb begin
    best_st = '0;
    best_m  = pm_new[0];
    for (int i = 1; i < NS; i++) begin
      if (pm_new[i] < best_m) begin
        best_m  = pm_new[i];
        best_st = SW'(i);
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && (fill >= FILL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_INIT;
        path[i] <= '0;
      end
      fill       <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_metric <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NS; i++) begin
          pm[i]   <= pm_new[i];
          path[i] <= path_new[i];
        end
        if (fill != FILL_FULL) fill <= fill + 1'b1;
      end
      if (load) begin
        out_valid  <= 1'b1;
        out_bit    <= path_new[best_st][TB_DEPTH-1];
        out_metric <= best_m;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed bench for viterbi_decoder_param: four parameterisations driven
// from a vector table plus handshake, reset, saturation and K=7 sequences.
module tb_viterbi_decoder_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_bit;
  logic [1:0] d_in_sym;
  logic [5:0] d_out_metric;
  logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_bit;
  logic [1:0] l_in_sym;
  logic [5:0] l_out_metric;
  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_bit;
  logic [1:0] w_in_sym;
  logic [3:0] w_out_metric;
  logic       g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_out_bit;
  logic [1:0] g_in_sym;
  logic [5:0] g_out_metric;

  viterbi_decoder_param u_dflt (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_sym(d_in_sym), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_bit(d_out_bit), .out_metric(d_out_metric));

  viterbi_decoder_param #(.TB_DEPTH(4)) u_short (
    .clk(clk), .reset(reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_sym(l_in_sym), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_bit(l_out_bit), .out_metric(l_out_metric));

  viterbi_decoder_param #(.METRIC_W(4)) u_narrow (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_sym(w_in_sym), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_bit(w_out_bit), .out_metric(w_out_metric));

  viterbi_decoder_param #(.K(7), .G0(7'b1111001), .G1(7'b1011011), .TB_DEPTH(35)) u_k7 (
    .clk(clk), .reset(reset), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_sym(g_in_sym), .out_valid(g_out_valid), .out_ready(g_out_ready),
    .out_bit(g_out_bit), .out_metric(g_out_metric));

  typedef struct {
    logic [1:0] sym;
    logic       vld;
    logic       obit;
    logic [5:0] met;
  } vec_t;

  vec_t       vt [20];
  logic       info7 [200];
  logic [1:0] sy7 [240];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoder: sr = {u, state}, state newest bit at k-2.
  function automatic logic [1:0] enc_sym(input int k, input logic [6:0] g0,
                                         input logic [6:0] g1, input logic [6:0] st,
                                         input logic u);
    logic [6:0] sr;
    sr = st | (7'(u) << (k - 1));
    return {^(sr & g0), ^(sr & g1)};
  endfunction

  function automatic logic [6:0] next_st(input int k, input logic [6:0] st, input logic u);
    return (st | (7'(u) << (k - 1))) >> 1;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_table(input bit corrupt);
    logic [1:0] y [6];
    logic       ib [6];
    y  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    ib = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int j = 0; j < 20; j++) begin
      vt[j].sym  = (j < 6) ? y[j] : 2'b00;
      vt[j].vld  = (j >= 14);
      vt[j].obit = 1'b0;
      if (j >= 14) vt[j].obit = ib[j-14];
      vt[j].met  = 6'd0;
    end
    if (corrupt) begin
      vt[2].sym  = 2'b10;
      vt[19].sym = 2'b01;
      vt[19].met = 6'd1;
    end
  endtask

  task automatic run_table(input string tag);
    for (int j = 0; j < 20; j++) begin
      if (j == 5) begin
        d_in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_valid"}, d_out_valid, 0);
      end
      d_in_valid  = 1'b1;
      d_in_sym    = vt[j].sym;
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_valid"}, d_out_valid, vt[j].vld);
      if (vt[j].vld) begin
        check({tag, "_bit"}, d_out_bit, vt[j].obit);
        check({tag, "_metric"}, d_out_metric, vt[j].met);
      end
    end
    d_in_valid = 1'b0;
  endtask

  task automatic run_backpressure();
    logic       info3 [12];
    logic [1:0] s3 [15];
    logic [6:0] st;
    int idx, rx, n_acc, cyc, stall_left;
    logic acc, drn;
    info3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    st = '0;
    for (int n = 0; n < 15; n++) begin
      logic u;
      u = (n < 12) ? info3[n] : 1'b0;
      s3[n] = enc_sym(3, 7'b0000111, 7'b0000101, st, u);
      st = next_st(3, st, u);
    end
    do_reset(2);
    idx = 0; rx = 0; n_acc = 0; cyc = 0; stall_left = 5;
    while (cyc < 200 && (idx < 15 || l_out_valid)) begin
      l_in_valid = (idx < 15);
      l_in_sym   = 2'b00;
      if (idx < 15) l_in_sym = s3[idx];
      if (n_acc >= 4 && stall_left > 0) begin
        l_out_ready = 1'b0;
        stall_left--;
      end else begin
        l_out_ready = (cyc % 3 != 1);
      end
      #1;
      if (l_out_valid && !l_out_ready) check("bp_stall_in_ready", l_in_ready, 0);
      else check("bp_in_ready", l_in_ready, 1);
      acc = l_in_valid && l_in_ready;
      drn = l_out_valid && l_out_ready;
      if (drn) begin
        if (rx < 12) check("bp_bit", l_out_bit, info3[rx]);
        rx++;
      end
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        idx++;
        if (n_acc == 3) check("lat_before_first", l_out_valid, 0);
        if (n_acc == 4) check("lat_first", l_out_valid, 1);
      end
      cyc++;
    end
    l_in_valid = 1'b0;
    check("bp_timeout", cyc < 200, 1);
    check("bp_count", rx, 12);
  endtask

  task automatic run_narrow();
    int outs;
    do_reset(2);
    outs = 0;
    for (int n = 0; n < 1000; n++) begin
      w_in_valid  = 1'b1;
      w_in_sym    = 2'($urandom_range(0, 3));
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      check("w4_no_x", 32'($isunknown({w_out_valid, w_out_bit, w_out_metric, w_in_ready})), 0);
      if (w_out_valid) begin
        check("w4_metric_le2", w_out_metric <= 4'd2, 1);
        outs++;
      end
    end
    w_in_valid = 1'b0;
    check("w4_out_count", outs, 986);
  endtask

  task automatic run_k7(input bit with_err, input string tag);
    logic [6:0] st;
    int cnt, nerr;
    logic expb;
    st = '0;
    for (int n = 0; n < 240; n++) begin
      logic u;
      u = (n < 200) ? info7[n] : 1'b0;
      sy7[n] = enc_sym(7, 7'b1111001, 7'b1011011, st, u);
      st = next_st(7, st, u);
    end
    if (with_err) begin
      for (int blk = 0; blk < 24; blk++) begin
        int p;
        p = blk * 10 + int'($urandom_range(0, 9));
        sy7[p] = sy7[p] ^ (2'b01 << $urandom_range(0, 1));
      end
    end
    do_reset(2);
    cnt = 0; nerr = 0;
    for (int n = 0; n < 240; n++) begin
      g_in_valid  = 1'b1;
      g_in_sym    = sy7[n];
      g_out_ready = 1'b1;
      @(posedge clk); #1;
      if (g_out_valid) begin
        expb = (cnt < 200) ? info7[cnt] : 1'b0;
        if (g_out_bit !== expb) nerr++;
        cnt++;
      end
    end
    g_in_valid = 1'b0;
    check({tag, "_bit_errors"}, nerr, 0);
    check({tag, "_out_count"}, cnt, 206);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    d_in_valid = 0; d_in_sym = 0; d_out_ready = 1;
    l_in_valid = 0; l_in_sym = 0; l_out_ready = 1;
    w_in_valid = 0; w_in_sym = 0; w_out_ready = 1;
    g_in_valid = 0; g_in_sym = 0; g_out_ready = 1;
    for (int n = 0; n < 200; n++) info7[n] = 1'($urandom_range(0, 1));

    do_reset(2);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_out_bit", d_out_bit, 0);
    check("rst_out_metric", d_out_metric, 0);
    check("rst_in_ready", d_in_ready, 1);

    fill_table(1'b0);
    run_table("clean");

    do_reset(2);
    fill_table(1'b1);
    run_table("err");

    // Seven symbols in flight, then a one-cycle reset with in_valid still high.
    do_reset(2);
    for (int n = 0; n < 7; n++) begin
      d_in_valid = 1'b1;
      d_in_sym   = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    do_reset(1);
    d_in_valid = 1'b0;
    check("midrst_out_valid", d_out_valid, 0);
    fill_table(1'b0);
    run_table("midrst");

    run_backpressure();
    run_narrow();
    run_k7(1'b0, "k7_clean");
    run_k7(1'b1, "k7_noisy");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
